// File: rtl/mealy_dual_pattern_detector.sv
// Dual serial pattern detector: two independent Mealy matchers share one bit
// history and each keeps its own fill tracker and saturating hit counter.

module mdpd_unit #(
    parameter int          LEN   = 3,
    parameter logic [15:0] PAT   = 16'b010,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr_cnt,
    input  logic [LEN-2:0]   hist,
    output logic             match,
    output logic [CNT_W-1:0] cnt
);
    localparam int FW = $clog2(16) + 1;
    localparam logic [FW-1:0] FULL = FW'(LEN - 1);

    logic [FW-1:0]  fill;
    logic [LEN-1:0] window;

    assign window = {hist, x};
    assign match  = en && (fill == FULL) && (window == PAT[LEN-1:0]);

    // fill counts accepted bits usable for the next hit; a non-overlapped
    // hit throws them all away so the next hit needs LEN fresh bits
    always_ff @(posedge clk) begin
        if (reset) begin
            fill <= '0;
        end else if (en) begin
            if (match && !overlap)
                fill <= '0;
            else if (fill != FULL)
                fill <= fill + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_cnt)
            cnt <= '0;
        else if (match && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module mealy_dual_pattern_detector #(
    parameter int          LEN_A = 3,
    parameter logic [15:0] PAT_A = 16'b010,
    parameter int          LEN_B = 4,
    parameter logic [15:0] PAT_B = 16'b1001,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             match_a,
    output logic             match_b,
    output logic             match_both,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);
    localparam int MAXL = (LEN_A > LEN_B) ? LEN_A : LEN_B;
    localparam int HW   = MAXL - 1;

    if (LEN_A < 2 || LEN_A > 16 || (PAT_A >> LEN_A) != 16'd0) begin : g_bad_a
        $error("pattern A: LEN_A out of range or PAT_A wider than LEN_A");
    end
    if (LEN_B < 2 || LEN_B > 16 || (PAT_B >> LEN_B) != 16'd0) begin : g_bad_b
        $error("pattern B: LEN_B out of range or PAT_B wider than LEN_B");
    end

    // hist[0] is the newest accepted bit
    logic [HW-1:0] hist;

    always_ff @(posedge clk) begin
        if (reset)
            hist <= '0;
        else if (en)
            hist <= HW'({hist, x});
    end

    mdpd_unit #(.LEN(LEN_A), .PAT(PAT_A), .CNT_W(CNT_W)) u_a (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .x       (x),
        .overlap (overlap),
        .clr_cnt (clr_cnt),
        .hist    (hist[LEN_A-2:0]),
        .match   (match_a),
        .cnt     (cnt_a)
    );

    mdpd_unit #(.LEN(LEN_B), .PAT(PAT_B), .CNT_W(CNT_W)) u_b (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .x       (x),
        .overlap (overlap),
        .clr_cnt (clr_cnt),
        .hist    (hist[LEN_B-2:0]),
        .match   (match_b),
        .cnt     (cnt_b)
    );

    assign match_both = match_a & match_b;
endmodule

// File: tb/tb_mealy_dual_pattern_detector.sv
// Table-driven bench: a default detector plus a 2-bit-counter variant whose
// pattern B (10) coincides with pattern A hits so match_both can be seen.

module tb_mealy_dual_pattern_detector;
    logic clk = 1'b0;
    logic reset, en, x, overlap, clr_cnt;

    logic       match_a, match_b, match_both;
    logic [7:0] cnt_a, cnt_b;
    logic       s_match_a, s_match_b, s_match_both;
    logic [1:0] s_cnt_a, s_cnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mealy_dual_pattern_detector u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .x          (x),
        .overlap    (overlap),
        .clr_cnt    (clr_cnt),
        .match_a    (match_a),
        .match_b    (match_b),
        .match_both (match_both),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b)
    );

    mealy_dual_pattern_detector #(
        .LEN_B (2),
        .PAT_B (16'b10),
        .CNT_W (2)
    ) u_sat (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .x          (x),
        .overlap    (overlap),
        .clr_cnt    (clr_cnt),
        .match_a    (s_match_a),
        .match_b    (s_match_b),
        .match_both (s_match_both),
        .cnt_a      (s_cnt_a),
        .cnt_b      (s_cnt_b)
    );

    typedef struct {
        logic       rst, en, x, ov, clr;
        logic       ea, eb;
        logic [7:0] ca, cb;
        logic       chk_sat;
        logic [1:0] sa;
        logic       sboth;
    } vec_t;

    vec_t tbl[$];
    int   step_no = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d required=%0d", name, step_no, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic e, input logic xi, input logic ov,
                       input logic clr, input logic ea, input logic eb,
                       input logic [7:0] ca, input logic [7:0] cb,
                       input logic cs, input logic [1:0] sa, input logic sboth);
        vec_t v;
        v.rst = rst; v.en = e; v.x = xi; v.ov = ov; v.clr = clr;
        v.ea = ea; v.eb = eb; v.ca = ca; v.cb = cb;
        v.chk_sat = cs; v.sa = sa; v.sboth = sboth;
        tbl.push_back(v);
    endtask

    // data bit with default-instance expectations only
    task automatic bit_row(input logic xi, input logic ov, input logic ea, input logic eb,
                           input logic [7:0] ca, input logic [7:0] cb);
        add(1'b0, 1'b1, xi, ov, 1'b0, ea, eb, ca, cb, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic rst_row();
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0);
    endtask

    // drive, check Mealy outputs mid-cycle, then check counters after the edge
    task automatic step(input vec_t v);
        reset = v.rst; en = v.en; x = v.x; overlap = v.ov; clr_cnt = v.clr;
        #2;
        chk("match_a", 8'(match_a), 8'(v.ea));
        chk("match_b", 8'(match_b), 8'(v.eb));
        chk("match_both", 8'(match_both), 8'(v.ea & v.eb));
        if (v.chk_sat) chk("sat_match_both", 8'(s_match_both), 8'(v.sboth));
        @(posedge clk);
        #1;
        chk("cnt_a", cnt_a, v.ca);
        chk("cnt_b", cnt_b, v.cb);
        if (v.chk_sat) chk("sat_cnt_a", 8'(s_cnt_a), 8'(v.sa));
        step_no++;
    endtask

    initial begin
        logic [7:0] sat_ca[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6};
        logic [1:0] sat_sa[13] = '{0, 0, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 3};
        vec_t v;

        // overlap=1, stream 0101001: A on 2 and 4, B on 6
        rst_row();
        bit_row(0, 1, 0, 0, 0, 0); bit_row(1, 1, 0, 0, 0, 0);
        bit_row(0, 1, 1, 0, 1, 0); bit_row(1, 1, 0, 0, 1, 0);
        bit_row(0, 1, 1, 0, 2, 0); bit_row(0, 1, 0, 0, 2, 0);
        bit_row(1, 1, 0, 1, 2, 1);
        // overlap=0, same stream: A only on 2
        rst_row();
        bit_row(0, 0, 0, 0, 0, 0); bit_row(1, 0, 0, 0, 0, 0);
        bit_row(0, 0, 1, 0, 1, 0); bit_row(1, 0, 0, 0, 1, 0);
        bit_row(0, 0, 0, 0, 1, 0); bit_row(0, 0, 0, 0, 1, 0);
        bit_row(1, 0, 0, 1, 1, 1);
        // overlap=1, stream 1001001: B on 3 and 6, A on 4
        rst_row();
        bit_row(1, 1, 0, 0, 0, 0); bit_row(0, 1, 0, 0, 0, 0);
        bit_row(0, 1, 0, 0, 0, 0); bit_row(1, 1, 0, 1, 0, 1);
        bit_row(0, 1, 1, 0, 1, 1); bit_row(0, 1, 0, 0, 1, 1);
        bit_row(1, 1, 0, 1, 1, 2);
        // en bubble between the 1 and the final 0; bubble x would complete 010
        rst_row();
        bit_row(0, 1, 0, 0, 0, 0); bit_row(1, 1, 0, 0, 0, 0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 2'd0, 1'b0);
        bit_row(0, 1, 1, 0, 1, 0);
        // reset mid-pattern discards 0,1
        rst_row();
        bit_row(0, 1, 0, 0, 0, 0); bit_row(1, 1, 0, 0, 0, 0);
        rst_row();
        bit_row(0, 1, 0, 0, 0, 0); bit_row(1, 1, 0, 0, 0, 0);
        bit_row(0, 1, 1, 0, 1, 0);
        // saturation: 6 overlapping 010 hits, 2-bit counter sticks at 3
        rst_row();
        for (int i = 0; i < 13; i++) begin
            logic hit;
            hit = (i % 2 == 0) && (i >= 2);
            add(1'b0, 1'b1, 1'(i % 2), 1'b1, 1'b0, hit, 1'b0, sat_ca[i], 8'd0,
                1'b1, sat_sa[i], hit);
        end
        // clr_cnt on a hit: pulse still seen, hit not counted
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6, 8'd0, 1'b1, 2'd3, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b1, 2'd1, 1'b1);

        reset = 1'b1; en = 1'b0; x = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // hand sequence: overlap dropped only on the hit bit forces 3 fresh bits
        v = '{rst: 1'b1, en: 1'b0, x: 1'b0, ov: 1'b0, clr: 1'b0, ea: 1'b0, eb: 1'b0,
              ca: 8'd0, cb: 8'd0, chk_sat: 1'b0, sa: 2'd0, sboth: 1'b0};
        step(v);
        v.rst = 1'b0; v.en = 1'b1; v.ov = 1'b1;
        v.x = 1'b0; step(v);
        v.x = 1'b1; step(v);
        v.x = 1'b0; v.ov = 1'b0; v.ea = 1'b1; v.ca = 8'd1; step(v);
        v.x = 1'b1; v.ov = 1'b1; v.ea = 1'b0; step(v);
        v.x = 1'b0; step(v);
        v.x = 1'b1; step(v);
        v.x = 1'b0; v.ea = 1'b1; v.ca = 8'd2; step(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
